// File: rtl/exec_unit_pkg.sv
// Execute-unit operand/op encodings and the decoded bundle carried from decode to execute.
package exec_unit_pkg;

  typedef logic [31:0] arch_reg;

  typedef enum logic { OP1_REG = 1'b0, OP1_PC  = 1'b1 } op1_sel_e;
  typedef enum logic { OP2_REG = 1'b0, OP2_IMM = 1'b1 } op2_sel_e;

  localparam logic [3:0] EXEC_ADD = 4'b0000;

  typedef struct packed {
    op1_sel_e   op1_sel;
    op2_sel_e   op2_sel;
    logic [3:0] exec_op;
  } exec_unit_params;

  typedef struct packed {
    arch_reg         pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    arch_reg         imm;
    exec_unit_params params;
    logic            illegal;
  } decoded_instr_t;

endpackage

// File: rtl/instructions_pkg.sv
// RV32 instruction encoding constants used by the decode front end.
package instructions_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_ADD = 3'b000;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the RV32 integer ALU subset (OP, OP-IMM, LUI, AUIPC).
module instr_decoder
  import exec_unit_pkg::*;
  import instructions_pkg::*;
(
  input  logic [31:0]    instr_i,
  input  arch_reg        pc_i,
  output decoded_instr_t dec_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  always_comb begin
    dec_o         = '0;
    dec_o.pc      = pc_i;
    dec_o.rs1     = instr_i[19:15];
    dec_o.rs2     = instr_i[24:20];
    dec_o.rd      = instr_i[11:7];
    dec_o.params  = '{op1_sel: OP1_REG, op2_sel: OP2_REG, exec_op: EXEC_ADD};
    dec_o.imm     = '0;
    dec_o.illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_o.params.exec_op = {instr_i[30], f3};
        dec_o.illegal = !((f7 == F7_ZERO) ||
                          ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
      end
      OPC_OP_IMM: begin
        dec_o.params.op2_sel = OP2_IMM;
        dec_o.params.exec_op = {1'b0, f3};
        dec_o.imm            = {{20{instr_i[31]}}, instr_i[31:20]};
        if (f3 == F3_SLL) begin
          dec_o.imm     = {27'b0, instr_i[24:20]};
          dec_o.illegal = (f7 != F7_ZERO);
        end else if (f3 == F3_SR) begin
          dec_o.params.exec_op = {instr_i[30], F3_SR};
          dec_o.imm            = {27'b0, instr_i[24:20]};
          dec_o.illegal        = (f7 != F7_ZERO) && (f7 != F7_ALT);
        end
      end
      OPC_LUI: begin
        dec_o.rs1            = '0;
        dec_o.params.op2_sel = OP2_IMM;
        dec_o.imm            = {instr_i[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec_o.params.op1_sel = OP1_PC;
        dec_o.params.op2_sel = OP2_IMM;
        dec_o.imm            = {instr_i[31:12], 12'b0};
      end
      default: dec_o.illegal = 1'b1;
    endcase
    // Any illegal word presents the neutral REG/REG/ADD bundle with a zero immediate.
    if (dec_o.illegal) begin
      dec_o.params = '{op1_sel: OP1_REG, op2_sel: OP2_REG, exec_op: EXEC_ADD};
      dec_o.imm    = '0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decoder on the input path, registered output with a one-entry skid buffer.
// Optional DECODE_STALL_CNT_EN adds a 32-bit count of output stall cycles on port stall_cnt.
module decode_stage
  import exec_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output exec_unit_params out_params,
  output logic            out_illegal
`ifdef DECODE_STALL_CNT_EN
  , output logic [31:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] { S_EMPTY, S_FULL, S_SKID } buf_state_e;

  buf_state_e     state_q;
  decoded_instr_t main_q, skid_q, dec;
  logic           in_ready_q, out_valid_q;
  logic           in_fire, out_fire;

  instr_decoder u_dec (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .dec_o   (dec)
  );

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: if (in_fire) begin
          main_q      <= dec;
          state_q     <= S_FULL;
          out_valid_q <= 1'b1;
        end
        S_FULL: begin
          if (in_fire && out_fire) begin
            main_q <= dec;
          end else if (in_fire) begin
            skid_q     <= dec;
            state_q    <= S_SKID;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        S_SKID: if (out_fire) begin
          main_q     <= skid_q;
          state_q    <= S_FULL;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = main_q.pc;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_imm     = main_q.imm;
  assign out_params  = main_q.params;
  assign out_illegal = main_q.illegal;

`ifdef DECODE_STALL_CNT_EN
  // Survives flush on purpose: it measures execute backpressure over the whole run.
  logic [31:0] stall_cnt_q, stall_cnt_d;
  assign stall_cnt_d = (out_valid_q && !out_ready) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver pushes expected bundles, a monitor pops on each output transfer.
module tb_decode_stage;
  import exec_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0]     in_instr, in_pc, out_pc, out_imm;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  exec_unit_params out_params;
`ifdef DECODE_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_params(out_params), .out_illegal(out_illegal)
`ifdef DECODE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // chk bits: [0] rs1, [1] rs2, [2] imm; pc, rd, params and illegal are always compared
  typedef struct {
    decoded_instr_t d;
    logic [2:0]     chk;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm, input op1_sel_e o1,
                              input op2_sel_e o2, input logic [3:0] eop, input logic ill,
                              input logic [2:0] chk);
    exp_t e;
    e.d.pc = pc; e.d.rs1 = rs1; e.d.rs2 = rs2; e.d.rd = rd; e.d.imm = imm;
    e.d.params.op1_sel = o1; e.d.params.op2_sel = o2; e.d.params.exec_op = eop;
    e.d.illegal = ill; e.chk = chk;
    return e;
  endfunction

  // Monitor: every output transfer must match the oldest expected bundle.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got pc %h want no output", out_pc);
        end else begin
          e  = sb.pop_front();
          ok = (out_pc === e.d.pc) && (out_rd === e.d.rd) && (out_params === e.d.params) &&
               (out_illegal === e.d.illegal) &&
               (!e.chk[0] || out_rs1 === e.d.rs1) && (!e.chk[1] || out_rs2 === e.d.rs2) &&
               (!e.chk[2] || out_imm === e.d.imm);
          if (!ok) begin
            n_fail++;
            $display("FAIL out_bundle: got pc=%h rs1=%0d rs2=%0d rd=%0d imm=%h params=%b ill=%b want pc=%h rs1=%0d rs2=%0d rd=%0d imm=%h params=%b ill=%b",
                     out_pc, out_rs1, out_rs2, out_rd, out_imm, out_params, out_illegal,
                     e.d.pc, e.d.rs1, e.d.rs2, e.d.rd, e.d.imm, e.d.params, e.d.illegal);
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
    int n = 0;
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
    else sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_pc", out_pc, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // single ADD: one-cycle latency
    out_ready = 1'b1;
    send(32'h002081B3, 32'h0, mk(32'h0, 1, 2, 3, 0, OP1_REG, OP2_REG, 4'b0000, 0, 3'b111));
    in_valid = 1'b0;
    @(negedge clk);
    check("add_latency_valid", {31'b0, out_valid}, 32'd1);
    idle(2);

    // back-to-back decode patterns
    send(32'h40335293, 32'h4,   mk(32'h4,   6, 3, 5, 32'h3,        OP1_REG, OP2_IMM, 4'b1101, 0, 3'b101));
    send(32'h12345097, 32'h100, mk(32'h100, 0, 0, 1, 32'h12345000, OP1_PC,  OP2_IMM, 4'b0000, 0, 3'b100));
    send(32'h000F83B7, 32'h104, mk(32'h104, 0, 0, 7, 32'h000F8000, OP1_REG, OP2_IMM, 4'b0000, 0, 3'b101));
    send(32'h40628233, 32'h108, mk(32'h108, 5, 6, 4, 0,            OP1_REG, OP2_REG, 4'b1000, 0, 3'b011));
    send(32'h0000006F, 32'h10C, mk(32'h10C, 0, 0, 0, 0,            OP1_REG, OP2_REG, 4'b0000, 1, 3'b100));
    send(32'h40109093, 32'h110, mk(32'h110, 0, 0, 1, 0,            OP1_REG, OP2_REG, 4'b0000, 1, 3'b000));
    idle(3);

    // A, B, C with execute stalled for three cycles
    out_ready = 1'b0;
    send(32'h00100093, 32'h200, mk(32'h200, 0, 0, 1, 32'h1, OP1_REG, OP2_IMM, 4'b0000, 0, 3'b101));
    send(32'h00200113, 32'h204, mk(32'h204, 0, 0, 2, 32'h2, OP1_REG, OP2_IMM, 4'b0000, 0, 3'b101));
    in_valid = 1'b0;
    @(negedge clk);
    check("skid_in_ready_low", {31'b0, in_ready}, 32'd0);
    check("skid_out_valid", {31'b0, out_valid}, 32'd1);
    check("skid_holds_a", out_pc, 32'h200);
    @(posedge clk); @(posedge clk); #1;
`ifdef DECODE_STALL_CNT_EN
    check("stall_cnt_3", stall_cnt, 32'd3);
`endif
    out_ready = 1'b1;
    send(32'hFFF00193, 32'h208, mk(32'h208, 0, 0, 3, 32'hFFFFFFFF, OP1_REG, OP2_IMM, 4'b0000, 0, 3'b101));
    idle(4);
    check("stream_drained", sb.size(), 32'd0);

    // flush while in SKID with a word offered on the input
    out_ready = 1'b0;
    send(32'h00100093, 32'h300, mk(32'h300, 0, 0, 1, 32'h1, OP1_REG, OP2_IMM, 4'b0000, 0, 3'b101));
    send(32'h00200113, 32'h304, mk(32'h304, 0, 0, 2, 32'h2, OP1_REG, OP2_IMM, 4'b0000, 0, 3'b101));
    in_valid = 1'b1; in_instr = 32'hFFF00193; in_pc = 32'h308; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef DECODE_STALL_CNT_EN
    check("stall_cnt_kept_by_flush", stall_cnt, 32'd5);
`endif
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("flush_nothing_emerges", {31'b0, out_valid}, 32'd0);

    // asynchronous reset mid-stream
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h002081B3, 32'h400, mk(32'h400, 1, 2, 3, 0, OP1_REG, OP2_REG, 4'b0000, 0, 3'b111));
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_out_pc", out_pc, 32'd0);
    check("arst_out_rd", {27'b0, out_rd}, 32'd0);
`ifdef DECODE_STALL_CNT_EN
    check("arst_stall_cnt", stall_cnt, 32'd0);
`endif
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;

    // recovery after reset
    out_ready = 1'b1;
    send(32'h40335293, 32'h500, mk(32'h500, 6, 3, 5, 32'h3, OP1_REG, OP2_IMM, 4'b1101, 0, 3'b101));
    idle(3);
    check("final_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
